// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: a pseudo-random countdown, then the LED lights and each
// player's reaction time is measured in ms ticks; results are early/good/late plus a winner.
module reaction_timer_multi #(
    parameter int          PLAYERS   = 4,
    parameter int          TICK_DIV  = 50000,
    parameter int          CNT_W     = 14,
    parameter int          TIMEOUT   = 9999,
    parameter int          MIN_DELAY = 1000,
    parameter int          RND_W     = 12,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [PLAYERS-1:0]       btn,
    output logic                     led,
    output logic [2:0]               state,
    output logic [PLAYERS*CNT_W-1:0] reaction,
    output logic [2*PLAYERS-1:0]     result,
    output logic [2:0]               winner,
    output logic                     winner_valid,
    output logic                     done
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] ALL_ONES  = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [1:0] RES_PEND = 2'b00, RES_EARLY = 2'b01, RES_GOOD = 2'b10, RES_LATE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_TEST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                     r_state, w_next;
    logic [15:0]                r_lfsr, w_lfsr_nx;
    logic [PLAYERS-1:0]         r_btn_prev, r_press;
    logic [PW-1:0]              r_presc;
    logic [CNT_W-1:0]           r_ms, r_delay;
    logic [PLAYERS*CNT_W-1:0]   r_reaction, w_reaction_nx;
    logic [2*PLAYERS-1:0]       r_result, w_result_nx;
    logic [2:0]                 r_winner, w_win_idx;
    logic                       r_winner_valid, w_win_valid, r_done;
    logic [CNT_W-1:0]           w_win_val;
    logic                       w_tick, w_start_round, w_all_resolved, w_state_chg, w_enter_done;

    assign w_lfsr_nx     = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_tick        = (r_presc == PW'(TICK_DIV - 1));
    assign w_start_round = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_state_chg   = (w_next != r_state);
    assign w_enter_done  = (w_next == S_DONE) && (r_state != S_DONE);

    // Per-player resolution for this cycle: presses first, then timeout for whoever is still pending.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_result_nx   = r_result;
        w_reaction_nx = r_reaction;
        if (w_start_round) begin
            w_result_nx   = '0;
            w_reaction_nx = '0;
        end else begin
            for (int i = 0; i < PLAYERS; i++) begin
                if (r_press[i] && r_result[2*i +: 2] == RES_PEND) begin
                    if (r_state == S_COUNTDOWN) begin
                        w_result_nx[2*i +: 2]         = RES_EARLY;
                        w_reaction_nx[i*CNT_W +: CNT_W] = ALL_ONES;
                    end else if (r_state == S_TEST) begin
                        w_result_nx[2*i +: 2]         = RES_GOOD;
                        w_reaction_nx[i*CNT_W +: CNT_W] = r_ms;
                    end
                end
            end
            if (r_state == S_TEST && r_ms == TIMEOUT_C) begin
                for (int i = 0; i < PLAYERS; i++) begin
                    if (w_result_nx[2*i +: 2] == RES_PEND) begin
                        w_result_nx[2*i +: 2]         = RES_LATE;
                        w_reaction_nx[i*CNT_W +: CNT_W] = TIMEOUT_C;
                    end
                end
            end
        end
    end

    always_comb begin
        w_all_resolved = 1'b1;
        w_win_valid    = 1'b0;
        w_win_idx      = '0;
        w_win_val      = ALL_ONES;
        for (int i = 0; i < PLAYERS; i++) begin
            if (w_result_nx[2*i +: 2] == RES_PEND)
                w_all_resolved = 1'b0;
            // Strict less-than keeps the lowest index on a tie.
            if (w_result_nx[2*i +: 2] == RES_GOOD &&
                (!w_win_valid || w_reaction_nx[i*CNT_W +: CNT_W] < w_win_val)) begin
                w_win_valid = 1'b1;
                w_win_idx   = 3'(i);
                w_win_val   = w_reaction_nx[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_ARM;
            S_ARM:       if (btn == '0) w_next = S_COUNTDOWN;
            S_COUNTDOWN: if (w_all_resolved) w_next = S_DONE;
                         else if (r_ms == r_delay) w_next = S_TEST;
            S_TEST:      if (w_all_resolved) w_next = S_DONE;
            S_DONE:      if (start) w_next = S_ARM;
            default:     w_next = S_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_lfsr         <= SEED;
            r_btn_prev     <= '0;
            r_press        <= '0;
            r_presc        <= '0;
            r_ms           <= '0;
            r_delay        <= '0;
            r_result       <= '0;
            r_reaction     <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_lfsr     <= w_lfsr_nx;
            r_btn_prev <= btn;
            r_press    <= btn & ~r_btn_prev;
            if (w_state_chg || w_tick) r_presc <= '0;
            else                       r_presc <= r_presc + 1'b1;
            if (w_state_chg)                       r_ms <= '0;
            else if (w_tick && r_ms != ALL_ONES)   r_ms <= r_ms + 1'b1;
            if (w_start_round)
                r_delay <= CNT_W'(MIN_DELAY) + CNT_W'(r_lfsr[RND_W-1:0]);
            r_result   <= w_result_nx;
            r_reaction <= w_reaction_nx;
            r_done     <= w_enter_done;
            if (w_start_round) begin
                r_winner       <= '0;
                r_winner_valid <= 1'b0;
            end else if (w_enter_done) begin
                r_winner       <= w_win_idx;
                r_winner_valid <= w_win_valid;
            end
        end
    end

    assign led          = (r_state == S_TEST);
    assign state        = r_state;
    assign reaction     = r_reaction;
    assign result       = r_result;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign done         = r_done;

endmodule
